// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg.
// slave is the stage side, master the driver/observer side.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 7,
  parameter int DATA_W = 121
);
  logic              valid_i;
  logic              ready_o;
  logic [CTRL_W-1:0] ctrl_i;
  logic [DATA_W-1:0] data_i;
  logic              flush_i;
  logic              valid_o;
  logic              ready_i;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0] data_o;
  logic [1:0]        count_o;

  modport slave (
    input  valid_i, ctrl_i, data_i,
    input  flush_i, ready_i,
    output ready_o, valid_o, ctrl_o,
    output data_o, count_o
  );

  modport master (
    output valid_i, ctrl_i, data_i,
    output flush_i, ready_i,
    input  ready_o, valid_o, ctrl_o,
    input  data_o, count_o
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with optional 2-entry skid buffer.
// Control is zeroed on bubble/flush; data only clears at reset.
module pipe_stage_reg #(
  parameter int CTRL_W = 7,
  parameter int DATA_W = 121,
  parameter bit SKID   = 1'b1
) (
  input logic            clk_i,
  input logic            start_i,
  pipe_stage_reg_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state, nxt;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  logic valid, ready, acc, rel;
  logic ld_main, ld_skid, shift;
  logic clr_main, clr_skid;

  assign valid = (state != EMPTY);
  assign ready = SKID ? (state != TWO)
                      : (bus.ready_i | ~valid);
  assign acc   = bus.valid_i & ready;
  assign rel   = valid & bus.ready_i;

  always_comb begin
    nxt      = state;
    ld_main  = 1'b0;
    ld_skid  = 1'b0;
    shift    = 1'b0;
    clr_main = 1'b0;
    clr_skid = 1'b0;
    if (bus.flush_i) begin
      nxt      = EMPTY;
      clr_main = 1'b1;
      clr_skid = 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc) begin
            ld_main = 1'b1;
            nxt     = ONE;
          end
        end
        ONE: begin
          unique case (1'b1)
            acc & rel: ld_main = 1'b1;
            acc & ~rel: begin
              if (SKID) begin
                ld_skid = 1'b1;
                nxt     = TWO;
              end
            end
            ~acc & rel: begin
              clr_main = 1'b1;
              nxt      = EMPTY;
            end
            default: ;
          endcase
        end
        TWO: begin
          if (rel) begin
            shift    = 1'b1;
            clr_skid = 1'b1;
            nxt      = ONE;
          end
        end
        default: nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) state <= EMPTY;
    else          state <= nxt;
  end

  // Data fields keep stale values on clear; only ctrl marks a NOP.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (clr_main) begin
        main_ctrl <= '0;
      end else if (ld_main) begin
        main_ctrl <= bus.ctrl_i;
        main_data <= bus.data_i;
      end else if (shift) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (clr_skid) begin
        skid_ctrl <= '0;
      end else if (ld_skid) begin
        skid_ctrl <= bus.ctrl_i;
        skid_data <= bus.data_i;
      end
    end
  end

  assign bus.valid_o = valid;
  assign bus.ready_o = ready;
  assign bus.ctrl_o  = main_ctrl;
  assign bus.data_o  = main_data;
  assign bus.count_o = state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg, SKID=1 and SKID=0.
// Stimulus pushes accepted beats; a negedge monitor pops on release.
module tb_pipe_stage_reg;
  localparam int CW = 7;
  localparam int DW = 121;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) a ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) b ();

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) u_skid (
    .clk_i(clk), .start_i(rst_n), .bus(a)
  );
  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) u_flat (
    .clk_i(clk), .start_i(rst_n), .bus(b)
  );

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, want);
    end
  endtask

  function automatic logic [CW-1:0] ctrl_of(input int k);
    return CW'(k * 5 + 1);
  endfunction

  function automatic logic [DW-1:0] data_of(input int k);
    logic [DW-1:0] d;
    d = DW'(k);
    d = (d << 96) | DW'(32'hC0DE_0000 + k);
    return d;
  endfunction

  task automatic cyc(input bit sel, input bit v,
                     input logic [CW-1:0] c,
                     input logic [DW-1:0] d,
                     input bit rdy, input bit fl);
    beat_t e;
    e.ctrl = c;
    e.data = d;
    if (!sel) begin
      a.valid_i = v; a.ctrl_i = c; a.data_i = d;
      a.ready_i = rdy; a.flush_i = fl;
    end else begin
      b.valid_i = v; b.ctrl_i = c; b.data_i = d;
      b.ready_i = rdy; b.flush_i = fl;
    end
    @(negedge clk);
    if (v && !fl) begin
      if (!sel && a.ready_o) qa.push_back(e);
      if (sel && b.ready_o)  qb.push_back(e);
    end
    @(posedge clk);
    if (fl) begin
      if (!sel) qa.delete();
      else      qb.delete();
    end
    #1;
  endtask

  task automatic beat(input bit sel, input int k,
                      input bit rdy, input bit fl);
    cyc(sel, 1'b1, ctrl_of(k), data_of(k), rdy, fl);
  endtask

  task automatic idle(input bit sel);
    cyc(sel, 1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (!a.valid_o) check("a_bubble", a.ctrl_o, 0);
      if (!b.valid_o) check("b_bubble", b.ctrl_o, 0);
      if (a.valid_o && a.ready_i) begin
        if (qa.size() == 0) begin
          checks++; failures++;
          $display("FAIL a_extra act=%0h exp=none", a.ctrl_o);
        end else begin
          e = qa.pop_front();
          check("a_ctrl", a.ctrl_o, e.ctrl);
          check("a_data", a.data_o, e.data);
        end
      end
      if (b.valid_o && b.ready_i) begin
        if (qb.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_extra act=%0h exp=none", b.ctrl_o);
        end else begin
          e = qb.pop_front();
          check("b_ctrl", b.ctrl_o, e.ctrl);
          check("b_data", b.data_o, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a.valid_i = 0; a.ctrl_i = '0; a.data_i = '0;
    a.ready_i = 0; a.flush_i = 0;
    b.valid_i = 0; b.ctrl_i = '0; b.data_i = '0;
    b.ready_i = 0; b.flush_i = 0;
    #2;
    check("a_rst_valid", a.valid_o, 0);
    check("a_rst_ctrl", a.ctrl_o, 0);
    check("a_rst_data", a.data_o, 0);
    check("a_rst_cnt", a.count_o, 0);
    check("a_rst_rdy", a.ready_o, 1);
    check("b_rst_valid", b.valid_o, 0);
    check("b_rst_cnt", b.count_o, 0);
    check("b_rst_rdy", b.ready_o, 1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      beat(0, k, 1, 0);
      check("a_stream_cnt", a.count_o, 1);
      check("a_stream_rdy", a.ready_o, 1);
    end
    idle(0);
    check("a_drain_cnt", a.count_o, 0);

    beat(0, 20, 0, 0);
    check("bp_cnt1", a.count_o, 1);
    check("bp_rdy1", a.ready_o, 1);
    beat(0, 21, 0, 0);
    check("bp_cnt2", a.count_o, 2);
    check("bp_rdy2", a.ready_o, 0);
    check("bp_hold", a.ctrl_o, ctrl_of(20));
    for (int i = 0; i < 2; i++) begin
      beat(0, 22, 0, 0);
      check("bp_cnt_st", a.count_o, 2);
      check("bp_rdy_st", a.ready_o, 0);
      check("bp_hold_st", a.ctrl_o, ctrl_of(20));
    end
    beat(0, 22, 1, 0);
    check("bp_rel_cnt", a.count_o, 1);
    check("bp_rel_rdy", a.ready_o, 1);
    check("bp_rel_head", a.ctrl_o, ctrl_of(21));
    beat(0, 22, 1, 0);
    check("bp_c_head", a.ctrl_o, ctrl_of(22));
    idle(0);
    check("bp_end_cnt", a.count_o, 0);

    beat(0, 30, 0, 0);
    beat(0, 31, 0, 0);
    check("fl_pre_cnt", a.count_o, 2);
    beat(0, 32, 0, 1);
    check("fl_valid", a.valid_o, 0);
    check("fl_ctrl", a.ctrl_o, 0);
    check("fl_cnt", a.count_o, 0);
    check("fl_rdy", a.ready_o, 1);
    beat(0, 33, 0, 0);
    beat(0, 34, 1, 1);
    check("fl1_valid", a.valid_o, 0);
    check("fl1_cnt", a.count_o, 0);
    beat(0, 35, 1, 0);
    idle(0);
    check("fl_after_cnt", a.count_o, 0);

    cyc(0, 1, 7'h7F, data_of(40), 1, 0);
    check("bub_ctrl", a.ctrl_o, 7'h7F);
    check("bub_valid", a.valid_o, 1);
    idle(0);
    check("bub_ctrl0", a.ctrl_o, 0);
    check("bub_valid0", a.valid_o, 0);
    check("bub_data", a.data_o, data_of(40));

    beat(0, 50, 0, 0);
    beat(0, 51, 0, 0);
    check("mr_pre_cnt", a.count_o, 2);
    rst_n = 1'b0;
    #1;
    check("mr_valid", a.valid_o, 0);
    check("mr_ctrl", a.ctrl_o, 0);
    check("mr_data", a.data_o, 0);
    check("mr_cnt", a.count_o, 0);
    check("mr_rdy", a.ready_o, 1);
    qa.delete();
    a.valid_i = 0;
    a.ready_i = 1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int k = 60; k < 65; k++) begin
      beat(1, k, 1, 0);
      check("b_stream_cnt", b.count_o, 1);
      check("b_stream_rdy", b.ready_o, 1);
    end
    idle(1);
    check("b_drain_cnt", b.count_o, 0);

    beat(1, 70, 1, 0);
    b.valid_i = 0;
    b.ready_i = 0; #1;
    check("b_rdy_f0", b.ready_o, 0);
    b.ready_i = 1; #1;
    check("b_rdy_f1", b.ready_o, 1);
    b.ready_i = 0; #1;
    check("b_rdy_f2", b.ready_o, 0);
    check("b_cnt_max", b.count_o, 1);
    @(posedge clk); #1;
    beat(1, 71, 0, 0);
    check("b_full_cnt", b.count_o, 1);
    check("b_full_head", b.ctrl_o, ctrl_of(70));
    beat(1, 71, 1, 0);
    check("b_pass_cnt", b.count_o, 1);
    check("b_pass_head", b.ctrl_o, ctrl_of(71));
    idle(1);
    check("b_end_cnt", b.count_o, 0);

    @(posedge clk); #1;
    check("a_sb_empty", qa.size(), 0);
    check("b_sb_empty", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
